// File: rtl/osc_frame_sched.sv
// Frame-level scheduler: sequences sample-store capture against HDMI vsync, manages the
// ping-pong buffer select and latches display parameters per frame. Optional: OSC_AUTO_TRIG_EN.
module osc_frame_sched #(
    parameter int AUTO_FRAMES = 8,
    parameter int CNT_W       = 16
) (
    input  logic             pix_clk,
    input  logic             rstn_out,
    input  logic             vs_in,
    input  logic             wr_over,
    input  logic             wave_run,
    input  logic             cap_done,
    input  logic [9:0]       v_shift_in,
    input  logic [9:0]       h_shift_in,
    input  logic [4:0]       v_scale_in,
    input  logic [8:0]       trig_line_in,
    output logic             cap_start,
    output logic             cap_abort,
    output logic             force_trig,
    output logic             wr_sel,
    output logic             rd_sel,
    output logic [9:0]       v_shift,
    output logic [9:0]       h_shift,
    output logic [4:0]       v_scale,
    output logic [8:0]       trig_line,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             busy
);

    if (AUTO_FRAMES < 1 || AUTO_FRAMES > 255) begin : g_bad_auto_frames
        $error("osc_frame_sched: AUTO_FRAMES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAPT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             vs_q;
    logic             vs_rise;
    logic             draw_done_q, draw_done_d;
    logic             wr_sel_q, wr_sel_d;
    logic             cap_start_q, cap_start_d;
    logic             cap_abort_q, cap_abort_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;
    logic [9:0]       v_shift_q, h_shift_q;
    logic [4:0]       v_scale_q;
    logic [8:0]       trig_line_q;

`ifdef OSC_AUTO_TRIG_EN
    localparam logic [7:0] AUTO_LIM = 8'(AUTO_FRAMES);
    logic [7:0] auto_cnt_q, auto_cnt_d;
    logic       force_trig_q, force_trig_d;
`endif

    assign vs_rise = vs_in & ~vs_q;

    always_comb begin
        state_d       = state_q;
        wr_sel_d      = wr_sel_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        cap_start_d   = 1'b0;
        cap_abort_d   = 1'b0;
`ifdef OSC_AUTO_TRIG_EN
        auto_cnt_d    = auto_cnt_q;
        force_trig_d  = 1'b0;
`endif
        // A new frame always invalidates the previous draw, even if wr_over lands with it.
        if (vs_rise) begin
            draw_done_d = 1'b0;
        end else if (wr_over) begin
            draw_done_d = 1'b1;
        end else begin
            draw_done_d = draw_done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (wave_run) begin
                    state_d     = ST_CAPT;
                    cap_start_d = 1'b1;
`ifdef OSC_AUTO_TRIG_EN
                    auto_cnt_d  = 8'd0;
`endif
                end
            end
            ST_CAPT: begin
                if (!wave_run) begin
                    state_d     = ST_IDLE;
                    cap_abort_d = 1'b1;
                end else if (cap_done) begin
                    state_d = ST_READY;
                end
`ifdef OSC_AUTO_TRIG_EN
                else if (vs_rise) begin
                    if (auto_cnt_q + 8'd1 == AUTO_LIM) begin
                        force_trig_d = 1'b1;
                        auto_cnt_d   = 8'd0;
                    end else begin
                        auto_cnt_d = auto_cnt_q + 8'd1;
                    end
                end
`endif
            end
            ST_READY: begin
                // The store is already idle here, so stopping needs no abort.
                if (!wave_run) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    if (draw_done_q) begin
                        wr_sel_d    = ~wr_sel_q;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = ST_CAPT;
                        cap_start_d = 1'b1;
`ifdef OSC_AUTO_TRIG_EN
                        auto_cnt_d  = 8'd0;
`endif
                    end else if (overrun_cnt_q != {CNT_W{1'b1}}) begin
                        overrun_cnt_d = overrun_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pix_clk or negedge rstn_out) begin
        if (!rstn_out) begin
            state_q       <= ST_IDLE;
            vs_q          <= 1'b0;
            draw_done_q   <= 1'b1;
            wr_sel_q      <= 1'b0;
            cap_start_q   <= 1'b0;
            cap_abort_q   <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs_in;
            draw_done_q   <= draw_done_d;
            wr_sel_q      <= wr_sel_d;
            cap_start_q   <= cap_start_d;
            cap_abort_q   <= cap_abort_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    // Parameters only move at a frame boundary so one drawn frame never mixes settings.
    always_ff @(posedge pix_clk or negedge rstn_out) begin
        if (!rstn_out) begin
            v_shift_q   <= '0;
            h_shift_q   <= '0;
            v_scale_q   <= '0;
            trig_line_q <= '0;
        end else if (vs_rise) begin
            v_shift_q   <= v_shift_in;
            h_shift_q   <= h_shift_in;
            v_scale_q   <= v_scale_in;
            trig_line_q <= trig_line_in;
        end
    end

`ifdef OSC_AUTO_TRIG_EN
    always_ff @(posedge pix_clk or negedge rstn_out) begin
        if (!rstn_out) begin
            auto_cnt_q   <= 8'd0;
            force_trig_q <= 1'b0;
        end else begin
            auto_cnt_q   <= auto_cnt_d;
            force_trig_q <= force_trig_d;
        end
    end
    assign force_trig = force_trig_q;
`else
    assign force_trig = 1'b0;
`endif

    assign cap_start   = cap_start_q;
    assign cap_abort   = cap_abort_q;
    assign wr_sel      = wr_sel_q;
    assign rd_sel      = ~wr_sel_q;
    assign v_shift     = v_shift_q;
    assign h_shift     = h_shift_q;
    assign v_scale     = v_scale_q;
    assign trig_line   = trig_line_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_osc_frame_sched.sv
// Self-checking bench for osc_frame_sched: frame-rule model compared every cycle plus
// hand-computed checkpoints along a directed scenario.
module tb_osc_frame_sched;

`ifdef OSC_AUTO_TRIG_EN
    localparam int AF = 3;
`else
    localparam int AF = 8;
`endif
    localparam int CW = 16;

    logic          pix_clk, rstn_out, vs_in, wr_over, wave_run, cap_done;
    logic [9:0]    v_shift_in, h_shift_in;
    logic [4:0]    v_scale_in;
    logic [8:0]    trig_line_in;
    logic          cap_start, cap_abort, force_trig, wr_sel, rd_sel, busy;
    logic [9:0]    v_shift, h_shift;
    logic [4:0]    v_scale;
    logic [8:0]    trig_line;
    logic [CW-1:0] frame_cnt, overrun_cnt;

    osc_frame_sched #(.AUTO_FRAMES(AF), .CNT_W(CW)) dut (
        .pix_clk(pix_clk), .rstn_out(rstn_out), .vs_in(vs_in), .wr_over(wr_over),
        .wave_run(wave_run), .cap_done(cap_done), .v_shift_in(v_shift_in),
        .h_shift_in(h_shift_in), .v_scale_in(v_scale_in), .trig_line_in(trig_line_in),
        .cap_start(cap_start), .cap_abort(cap_abort), .force_trig(force_trig),
        .wr_sel(wr_sel), .rd_sel(rd_sel), .v_shift(v_shift), .h_shift(h_shift),
        .v_scale(v_scale), .trig_line(trig_line), .frame_cnt(frame_cnt),
        .overrun_cnt(overrun_cnt), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        pix_clk = 1'b0;
        forever #5 pix_clk = ~pix_clk;
    end

    // Model: the scheduler described as "mode", "which half is shown", "was the
    // last frame fully drawn", and the frame-boundary bookkeeping.
    localparam int M_IDLE = 0, M_CAPT = 1, M_READY = 2;
    int          m_mode, m_frames, m_overruns, m_auto;
    bit          m_wr_half, m_start, m_abort, m_force, m_drawn, m_vs_prev;
    logic [9:0]  m_vsh, m_hsh;
    logic [4:0]  m_vsc;
    logic [8:0]  m_trg;

    task automatic model_reset();
        m_mode = M_IDLE; m_frames = 0; m_overruns = 0; m_auto = 0;
        m_wr_half = 0; m_start = 0; m_abort = 0; m_force = 0; m_drawn = 1; m_vs_prev = 0;
        m_vsh = '0; m_hsh = '0; m_vsc = '0; m_trg = '0;
    endtask

    // Predict the state after the coming clock edge from the inputs it will sample.
    task automatic model_step();
        bit new_frame;
        bit was_drawn;
        new_frame = vs_in && !m_vs_prev;
        was_drawn = m_drawn;
        m_start = 0; m_abort = 0; m_force = 0;
        if (new_frame) begin
            m_vsh = v_shift_in; m_hsh = h_shift_in; m_vsc = v_scale_in; m_trg = trig_line_in;
            m_drawn = 0;
        end else if (wr_over) begin
            m_drawn = 1;
        end
        if (m_mode == M_IDLE) begin
            if (wave_run) begin m_mode = M_CAPT; m_start = 1; m_auto = 0; end
        end else if (m_mode == M_CAPT) begin
            if (!wave_run) begin m_mode = M_IDLE; m_abort = 1; end
            else if (cap_done) m_mode = M_READY;
`ifdef OSC_AUTO_TRIG_EN
            else if (new_frame) begin
                m_auto++;
                if (m_auto == AF) begin m_force = 1; m_auto = 0; end
            end
`endif
        end else begin
            if (!wave_run) m_mode = M_IDLE;
            else if (new_frame && was_drawn) begin
                m_wr_half = !m_wr_half;
                m_frames  = (m_frames + 1) % (1 << CW);
                m_mode    = M_CAPT; m_start = 1; m_auto = 0;
            end else if (new_frame && m_overruns < (1 << CW) - 1) begin
                m_overruns++;
            end
        end
        m_vs_prev = vs_in;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge pix_clk);
            if (!rstn_out) model_reset();
            check("cap_start",   cap_start,   m_start);
            check("cap_abort",   cap_abort,   m_abort);
            check("force_trig",  force_trig,  m_force);
            check("wr_sel",      wr_sel,      m_wr_half);
            check("rd_sel",      rd_sel,      !m_wr_half);
            check("busy",        busy,        m_mode != M_IDLE);
            check("frame_cnt",   frame_cnt,   m_frames);
            check("overrun_cnt", overrun_cnt, m_overruns);
            check("v_shift",     v_shift,     m_vsh);
            check("h_shift",     h_shift,     m_hsh);
            check("v_scale",     v_scale,     m_vsc);
            check("trig_line",   trig_line,   m_trg);
            check("one_pulse",   int'(cap_start & cap_abort), 0);
            if (rstn_out) model_step();
        end
    end

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    int force_seen;
    int first_force;

    initial begin
        rstn_out = 1'b1; vs_in = 0; wr_over = 0; wave_run = 0; cap_done = 0;
        v_shift_in = 10'h155; h_shift_in = 10'h0AA; v_scale_in = 5'h03; trig_line_in = 9'h1C3;
        #2 rstn_out = 1'b0;
        tick(); tick(); tick();
        rstn_out = 1'b1;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_rd_sel", rd_sel, 1);
        check("rst_frame_cnt", frame_cnt, 0);

        // Start capture
        wave_run = 1; tick();
        check("start_pulse", cap_start, 1);
        check("start_wr_sel", wr_sel, 0);
        check("start_busy", busy, 1);
        tick();
        check("start_single", cap_start, 0);

        // Fill, draw finished, frame boundary -> swap
        cap_done = 1; tick(); cap_done = 0;
        v_scale_in = 5'h12; wr_over = 1; tick(); wr_over = 0;
        vs_in = 1; tick();
        check("swap_wr_sel", wr_sel, 1);
        check("swap_rd_sel", rd_sel, 0);
        check("swap_frame_cnt", frame_cnt, 1);
        check("swap_cap_start", cap_start, 1);
        check("swap_v_scale", v_scale, 5'h12);
        vs_in = 0; tick();

        // Ready without a finished draw -> overrun, then swap after wr_over
        cap_done = 1; tick(); cap_done = 0; tick();
        v_shift_in = 10'h2F0; vs_in = 1; tick();
        check("ovr_cnt", overrun_cnt, 1);
        check("ovr_wr_sel", wr_sel, 1);
        check("ovr_frame_cnt", frame_cnt, 1);
        check("ovr_v_shift", v_shift, 10'h2F0);
        vs_in = 0; tick();
        wr_over = 1; tick(); wr_over = 0;
        vs_in = 1; tick();
        check("swap2_frame_cnt", frame_cnt, 2);
        check("swap2_wr_sel", wr_sel, 0);
        vs_in = 0; tick();

        // Stop together with cap_done in CAPT -> abort, no swap
        wave_run = 0; cap_done = 1; tick(); cap_done = 0;
        check("stop_abort", cap_abort, 1);
        check("stop_busy", busy, 0);
        check("stop_rd_sel", rd_sel, 1);
        check("stop_frame_cnt", frame_cnt, 2);
        tick();
        check("stop_abort_single", cap_abort, 0);

        // Stop in READY -> idle, no abort
        wave_run = 1; tick();
        cap_done = 1; tick(); cap_done = 0;
        wave_run = 0; tick();
        check("ready_stop_abort", cap_abort, 0);
        check("ready_stop_busy", busy, 0);

        // cap_done coincident with frame start in CAPT: READY, swap deferred
        wave_run = 1; tick(); tick();
        cap_done = 1; vs_in = 1; h_shift_in = 10'h111; tick();
        cap_done = 0; vs_in = 0;
        check("coinc_wr_sel", wr_sel, 0);
        check("coinc_frame_cnt", frame_cnt, 2);
        tick();
        wr_over = 1; tick(); wr_over = 0;
        vs_in = 1; tick(); vs_in = 0;
        check("coinc_swap_frame_cnt", frame_cnt, 3);
        tick();

        // Ten frames in CAPT with no cap_done
        force_seen = 0; first_force = 0;
        for (int i = 1; i <= 10; i++) begin
            vs_in = 1; tick(); vs_in = 0;
            if (force_trig) begin
                force_seen++;
                if (first_force == 0) first_force = i;
            end
            tick(); tick();
        end
`ifdef OSC_AUTO_TRIG_EN
        check("auto_force_count", force_seen, 3);
        check("auto_first_force", first_force, 3);
`else
        check("auto_force_count", force_seen, 0);
`endif
        check("auto_still_busy", busy, 1);

        // Asynchronous reset mid-CAPT, then fresh start
        trig_line_in = 9'h0F0;
        vs_in = 1; tick(); vs_in = 0;
        rstn_out = 0; #2;
        check("arst_busy", busy, 0);
        check("arst_wr_sel", wr_sel, 0);
        check("arst_rd_sel", rd_sel, 1);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_overrun_cnt", overrun_cnt, 0);
        check("arst_trig_line", trig_line, 0);
        tick();
        rstn_out = 1; tick();
        check("rerun_start", cap_start, 1);
        check("rerun_busy", busy, 1);
        tick();
        wave_run = 0; tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
